// File: rtl/i2c_ioexp_target.sv
// I2C target emulating a 16-bit I/O expander: pointer byte plus auto-incrementing data bytes.
// Registers 0/1 read the input pins. Registers 2/3 read and write the output register.
module i2c_ioexp_target #(
    parameter logic [6:0]  ADDR      = 7'h20,
    parameter logic [15:0] OUT_RESET = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        sdata,
    output logic        sdata_oe_n,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        out_strobe,
    output logic        busy
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StWdata, StWack, StRdata, StRack, StWaitStop
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_prev_q, sda_prev_q;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        oe_n_q, oe_n_d;
    logic [15:0] out_q, out_d;
    logic        strobe_q, strobe_d;

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rd_byte, wr_byte;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign wr_byte   = {shreg_q[6:0], sda_s};

    always_comb begin
        case (ptr_q)
            2'd0:    rd_byte = in[7:0];
            2'd1:    rd_byte = in[15:8];
            2'd2:    rd_byte = out_q[7:0];
            default: rd_byte = out_q[15:8];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        ptr_d    = ptr_q;
        rw_d     = rw_q;
        oe_n_d   = oe_n_q;
        out_d    = out_q;
        strobe_d = 1'b0;
        // Bus conditions win over any bit activity in the same cycle.
        if (start_det) begin
            state_d  = StAddr;
            bitcnt_d = 4'd0;
            oe_n_d   = 1'b1;
        end else if (stop_det) begin
            state_d = StIdle;
            oe_n_d  = 1'b1;
        end else begin
            case (state_q)
                StAddr, StPtr: begin
                    if (scl_rise) begin
                        shreg_d  = wr_byte;
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        if (state_q == StAddr && shreg_q[7:1] == ADDR) begin
                            rw_d    = shreg_q[0];
                            oe_n_d  = 1'b0;
                            state_d = StAddrAck;
                        end else if (state_q == StPtr && shreg_q[7:2] == 6'd0) begin
                            ptr_d   = shreg_q[1:0];
                            oe_n_d  = 1'b0;
                            state_d = StWack;
                        end else begin
                            state_d = StWaitStop;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        bitcnt_d = 4'd0;
                        if (rw_q) begin
                            shreg_d = rd_byte;
                            oe_n_d  = rd_byte[7];
                            state_d = StRdata;
                        end else begin
                            oe_n_d  = 1'b1;
                            state_d = StPtr;
                        end
                    end
                end
                StWdata: begin
                    if (scl_rise) begin
                        shreg_d  = wr_byte;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            if (ptr_q[1]) begin
                                strobe_d = 1'b1;
                                if (ptr_q[0]) out_d[15:8] = wr_byte;
                                else          out_d[7:0]  = wr_byte;
                            end
                            ptr_d[0] = ~ptr_q[0];
                        end
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        oe_n_d  = 1'b0;
                        state_d = StWack;
                    end
                end
                StWack: begin
                    if (scl_fall) begin
                        oe_n_d   = 1'b1;
                        bitcnt_d = 4'd0;
                        state_d  = StWdata;
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        shreg_d  = {shreg_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            oe_n_d   = 1'b1;
                            bitcnt_d = 4'd0;
                            ptr_d[0] = ~ptr_q[0];
                            state_d  = StRack;
                        end else begin
                            oe_n_d = shreg_q[7];
                        end
                    end
                end
                StRack: begin
                    // bitcnt marks that the controller ACKed on the rising edge.
                    if (scl_rise) begin
                        if (sda_s) state_d  = StWaitStop;
                        else       bitcnt_d = 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd1) begin
                        shreg_d  = rd_byte;
                        oe_n_d   = rd_byte[7];
                        bitcnt_d = 4'd0;
                        state_d  = StRdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= StIdle;
            bitcnt_q   <= 4'd0;
            shreg_q    <= 8'd0;
            ptr_q      <= 2'd0;
            rw_q       <= 1'b0;
            oe_n_q     <= 1'b1;
            out_q      <= OUT_RESET;
            strobe_q   <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], sclk};
            sda_sync_q <= {sda_sync_q[0], sdata};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            oe_n_q     <= oe_n_d;
            out_q      <= out_d;
            strobe_q   <= strobe_d;
        end
    end

    assign sdata_oe_n = oe_n_q;
    assign out        = out_q;
    assign out_strobe = strobe_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_ioexp_target.sv
// Directed bench for i2c_ioexp_target: bit-banged I2C controller on a wired-AND SDA line.
module tb_i2c_ioexp_target;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scl = 1'b1;
    logic        sda_tb = 1'b1;
    logic        sda_bus;
    logic        sdata_oe_n;
    logic [15:0] in_pins = 16'h0000;
    logic [15:0] out_reg;
    logic        out_strobe;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int strobe_cnt = 0;
    int oe_low_cnt = 0;

    assign sda_bus = sda_tb & sdata_oe_n;

    i2c_ioexp_target #(.ADDR(7'h20), .OUT_RESET(16'hFFFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (scl),
        .sdata      (sda_bus),
        .sdata_oe_n (sdata_oe_n),
        .in         (in_pins),
        .out        (out_reg),
        .out_strobe (out_strobe),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_strobe) strobe_cnt <= strobe_cnt + 1;
        if (!sdata_oe_n) oe_low_cnt <= oe_low_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Quarter SCL period: 8 clk cycles, stepping on the falling clk edge.
    task automatic q;
        repeat (8) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_tb = 1'b1; scl = 1'b1; q();
        sda_tb = 1'b0; q();
        scl = 1'b0; q();
    endtask

    task automatic i2c_repstart;
        sda_tb = 1'b1; q();
        scl = 1'b1; q();
        sda_tb = 1'b0; q();
        scl = 1'b0; q();
    endtask

    task automatic i2c_stop;
        sda_tb = 1'b0; q();
        scl = 1'b1; q();
        sda_tb = 1'b1; q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_tb = b[i]; q();
            scl = 1'b1; q(); q();
            scl = 1'b0; q();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_tb = 1'b1; q();
        scl = 1'b1; q();
        ack = sda_bus; q();
        scl = 1'b0; q();
    endtask

    task automatic read_byte(input logic do_ack, output logic [7:0] b);
        sda_tb = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            q();
            scl = 1'b1; q();
            b[i] = sda_bus; q();
            scl = 1'b0;
        end
        q();
        sda_tb = ~do_ack; q();
        scl = 1'b1; q(); q();
        scl = 1'b0; q();
        sda_tb = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         s0, o0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_oe_n", {15'd0, sdata_oe_n}, 16'h0001);
        check("rst_out", out_reg, 16'hFFFF);
        check("rst_strobe", {15'd0, out_strobe}, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'h0000);
        reset = 1'b1;
        q();

        // Write 00 to reg 2, FF to reg 3
        s0 = strobe_cnt;
        i2c_start();
        check("t1_busy_start", {15'd0, busy}, 16'h0001);
        write_byte(8'h40, ack); check("t1_ack_addr", {15'd0, ack}, 16'h0000);
        write_byte(8'h02, ack); check("t1_ack_ptr", {15'd0, ack}, 16'h0000);
        write_byte(8'h00, ack); check("t1_ack_d0", {15'd0, ack}, 16'h0000);
        check("t1_out_mid", out_reg, 16'hFF00);
        write_byte(8'hFF, ack); check("t1_ack_d1", {15'd0, ack}, 16'h0000);
        check("t1_busy_pre_stop", {15'd0, busy}, 16'h0001);
        i2c_stop();
        check("t1_out", out_reg, 16'hFF00);
        check("t1_strobes", 16'(strobe_cnt - s0), 16'd2);
        check("t1_busy_stop", {15'd0, busy}, 16'h0000);

        // Write 55, AA with auto-increment
        i2c_start();
        write_byte(8'h40, ack); check("t2_ack_addr", {15'd0, ack}, 16'h0000);
        write_byte(8'h02, ack); check("t2_ack_ptr", {15'd0, ack}, 16'h0000);
        write_byte(8'h55, ack); check("t2_ack_d0", {15'd0, ack}, 16'h0000);
        write_byte(8'hAA, ack); check("t2_ack_d1", {15'd0, ack}, 16'h0000);
        i2c_stop();
        check("t2_out", out_reg, 16'hAA55);

        // Pointer write, repeated START, two-byte read of input pins
        in_pins = 16'h1234;
        i2c_start();
        write_byte(8'h40, ack); check("t3_ack_addr", {15'd0, ack}, 16'h0000);
        write_byte(8'h00, ack); check("t3_ack_ptr", {15'd0, ack}, 16'h0000);
        i2c_repstart();
        write_byte(8'h41, ack); check("t3_ack_raddr", {15'd0, ack}, 16'h0000);
        read_byte(1'b1, rb); check("t3_rd0", {8'd0, rb}, 16'h0034);
        read_byte(1'b0, rb); check("t3_rd1", {8'd0, rb}, 16'h0012);
        q();
        check("t3_oe_released", {15'd0, sdata_oe_n}, 16'h0001);
        check("t3_busy_waitstop", {15'd0, busy}, 16'h0001);
        o0 = oe_low_cnt;
        q(); q();
        check("t3_no_drive", 16'(oe_low_cnt - o0), 16'd0);
        i2c_stop();

        // Wrong address: nothing acknowledged, SDA never pulled
        o0 = oe_low_cnt;
        i2c_start();
        write_byte(8'h42, ack); check("t4_nack_addr", {15'd0, ack}, 16'h0001);
        write_byte(8'h02, ack); check("t4_nack_b1", {15'd0, ack}, 16'h0001);
        write_byte(8'h00, ack); check("t4_nack_b2", {15'd0, ack}, 16'h0001);
        i2c_stop();
        check("t4_out", out_reg, 16'hAA55);
        check("t4_oe_never_low", 16'(oe_low_cnt - o0), 16'd0);

        // Out-of-range pointer
        i2c_start();
        write_byte(8'h40, ack); check("t5_ack_addr", {15'd0, ack}, 16'h0000);
        write_byte(8'h05, ack); check("t5_nack_ptr", {15'd0, ack}, 16'h0001);
        write_byte(8'h12, ack); check("t5_nack_data", {15'd0, ack}, 16'h0001);
        i2c_stop();
        check("t5_out", out_reg, 16'hAA55);

        // STOP after 4 bits of a data byte
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h40, ack); check("t6_ack_addr", {15'd0, ack}, 16'h0000);
        write_byte(8'h02, ack); check("t6_ack_ptr", {15'd0, ack}, 16'h0000);
        send_bits(8'h00, 4);
        i2c_stop();
        check("t6_out", out_reg, 16'hAA55);
        check("t6_no_strobe", 16'(strobe_cnt - s0), 16'd0);

        // Reset during the address ACK
        i2c_start();
        send_bits(8'h40, 8);
        sda_tb = 1'b1; q();
        check("t7_ack_driven", {15'd0, sdata_oe_n}, 16'h0000);
        reset = 1'b0;
        #1;
        check("t7_rst_oe_n", {15'd0, sdata_oe_n}, 16'h0001);
        check("t7_rst_out", out_reg, 16'hFFFF);
        check("t7_rst_busy", {15'd0, busy}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        scl = 1'b1; q(); q();
        scl = 1'b0; q();
        check("t7_idle_after", {15'd0, busy}, 16'h0000);
        i2c_stop();
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h40, ack); check("t7_ack_addr", {15'd0, ack}, 16'h0000);
        write_byte(8'h03, ack); check("t7_ack_ptr", {15'd0, ack}, 16'h0000);
        write_byte(8'h0F, ack); check("t7_ack_data", {15'd0, ack}, 16'h0000);
        i2c_stop();
        check("t7_out", out_reg, 16'h0FFF);
        check("t7_strobe", 16'(strobe_cnt - s0), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
